// File: rtl/pwm_dtgen.sv
// Centre-aligned three-phase PWM with double-buffered duty and per-leg dead-time.
// Carrier is an up/down counter; duty is applied at the valley, and a latched fault forces all gates off.

package pwm_dtgen_pkg;
  localparam int unsigned DUTY_W = 18;

  typedef struct packed {
    logic clk;
    logic rstn;
    logic ce;
  } clock_t;

  typedef struct packed {
    logic [2:0][DUTY_W-1:0] data;
    logic                   val;
  } ph_data_t;

  typedef enum logic [1:0] {
    SAFE = 2'd0,
    LOW  = 2'd1,
    DEAD = 2'd2,
    HIGH = 2'd3
  } gate_state_e;
endpackage

module pwm_dtgen
  import pwm_dtgen_pkg::*;
#(
  parameter int unsigned PERIOD   = 2500,
  parameter int unsigned DEADTIME = 50,
  parameter int unsigned CW       = DUTY_W  // must equal the width of duty.data elements
) (
  input  clock_t     clock,
  input  ph_data_t   duty,
  input  logic       enable,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [2:0] pwm_h,
  output logic [2:0] pwm_l,
  output logic       sync,
  output logic       fault_latched
);

  localparam int unsigned CNTW = $clog2(PERIOD + 1);
  localparam int unsigned DW   = $clog2(DEADTIME) + 1;

  logic clk, rst_n;
  logic unused_ce;
  assign clk       = clock.clk;
  assign rst_n     = clock.rstn;
  assign unused_ce = clock.ce;

  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   up_q, up_d;
  logic                   sync_q;
  logic                   wrap;
  logic [2:0][CW-1:0]     pend_q, cmp_q;
  logic                   pend_flag_q;
  logic [2:0]             ref_q, ref_d, ref_prev_q;
  logic                   flt_q;
  logic                   gate_off;
  gate_state_e            state_q [3];
  gate_state_e            state_d [3];
  logic [DW-1:0]          dcnt_q [3];
  logic [DW-1:0]          dcnt_d [3];

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
    if (v[CW-1])               return '0;
    else if (v > CW'(PERIOD))  return CW'(PERIOD);
    else                       return v;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (up_q) begin
      if (cnt_q == CNTW'(PERIOD - 1)) begin
        cnt_d = CNTW'(PERIOD);
        up_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNTW'(1)) up_d = 1'b1;
    end
  end

  // The 1 -> 0 step of the carrier: shadow load point and sync source.
  assign wrap = !up_q && (cnt_q == CNTW'(1));

  always_comb begin
    ref_d = '0;
    for (int k = 0; k < 3; k++) begin
      ref_d[k] = up_q ? (CW'(cnt_q) <  cmp_q[k])
                      : (CW'(cnt_q) <= cmp_q[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: pend/cmp are a handful of flops, not a RAM, so they take a defined reset value like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      up_q        <= 1'b1;
      sync_q      <= 1'b0;
      pend_q      <= '0;
      cmp_q       <= '0;
      pend_flag_q <= 1'b0;
      ref_q       <= '0;
      ref_prev_q  <= '0;
      flt_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      up_q       <= up_d;
      sync_q     <= wrap;
      ref_q      <= ref_d;
      ref_prev_q <= ref_q;
      // A strobe on the load edge wins the flag, so the new value waits one more period.
      if (duty.val) begin
        for (int k = 0; k < 3; k++) pend_q[k] <= clamp(duty.data[k]);
        pend_flag_q <= 1'b1;
      end else if (wrap) begin
        pend_flag_q <= 1'b0;
      end
      if (wrap && pend_flag_q) cmp_q <= pend_q;
      if (fault)          flt_q <= 1'b1;
      else if (fault_clr) flt_q <= 1'b0;
    end
  end

  assign gate_off = !enable || flt_q || fault;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      dcnt_d[k]  = dcnt_q[k];
      if (gate_off) begin
        state_d[k] = SAFE;
      end else begin
        unique case (state_q[k])
          SAFE: begin
            state_d[k] = DEAD;
            dcnt_d[k]  = '0;
          end
          LOW: if (ref_q[k]) begin
            state_d[k] = DEAD;
            dcnt_d[k]  = '0;
          end
          HIGH: if (!ref_q[k]) begin
            state_d[k] = DEAD;
            dcnt_d[k]  = '0;
          end
          DEAD: begin
            if (ref_q[k] != ref_prev_q[k]) begin
              dcnt_d[k] = '0;
            end else if (dcnt_q[k] == DW'(DEADTIME - 1)) begin
              state_d[k] = ref_q[k] ? HIGH : LOW;
            end else begin
              dcnt_d[k] = dcnt_q[k] + 1'b1;
            end
          end
          default: state_d[k] = SAFE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= SAFE;
        dcnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        dcnt_q[k]  <= dcnt_d[k];
      end
    end
  end

  always_comb begin
    pwm_h = '0;
    pwm_l = '0;
    for (int k = 0; k < 3; k++) begin
      pwm_h[k] = (state_q[k] == HIGH);
      pwm_l[k] = (state_q[k] == LOW);
    end
  end

  assign sync          = sync_q;
  assign fault_latched = flt_q;

endmodule

// File: tb/tb_pwm_dtgen.sv
// Directed bench for pwm_dtgen at PERIOD=2500, DEADTIME=50: start-up, duty/dead-time timing,
// shadow loading, fault latch, clamping and reset; expected values are worked out by hand.

module tb_pwm_dtgen;
  import pwm_dtgen_pkg::*;

  localparam int P     = 2500;
  localparam int D     = 50;
  localparam int CW    = 18;
  localparam int LIMIT = 12000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  clock_t     clock;
  ph_data_t   duty;
  logic       enable, fault, fault_clr;
  logic [2:0] pwm_h, pwm_l;
  logic       sync, fault_latched;

  assign clock = {clk, rst_n, 1'b1};

  pwm_dtgen #(.PERIOD(P), .DEADTIME(D), .CW(CW)) dut (
    .clock         (clock),
    .duty          (duty),
    .enable        (enable),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .sync          (sync),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles since reset release, as seen at the following negedge.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int overlap_cnt = 0, h0_hi = 0, l0_lo = 0, h1_hi = 0, h2_lo = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(pwm_h & pwm_l)) overlap_cnt++;
      if (pwm_h[0])         h0_hi++;
      if (!pwm_l[0])        l0_lo++;
      if (pwm_h[1])         h1_hi++;
      if (!pwm_h[2])        h2_lo++;
    end
  end

  function automatic bit sig(input int ph, input int sel);
    if (sel == 0)      return pwm_h[ph];
    else if (sel == 1) return pwm_l[ph];
    else               return pwm_h[ph] | pwm_l[ph];
  endfunction

  // Length of the next complete run of sig(ph,sel)==level; -1 when the bound expires.
  task automatic measure_run(input int ph, input int sel, input bit level, output int len);
    int n;
    n   = 0;
    len = 0;
    while (sig(ph, sel) == level && n < LIMIT) begin @(negedge clk); n++; end
    while (sig(ph, sel) != level && n < LIMIT) begin @(negedge clk); n++; end
    while (sig(ph, sel) == level && n < LIMIT) begin @(negedge clk); n++; len++; end
    if (n >= LIMIT) len = -1;
  endtask

  task automatic wait_sync(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!sync && n < LIMIT) begin @(negedge clk); n++; end
    check(tag, {31'd0, sync}, 32'd1);
  endtask

  task automatic write_duty(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c);
    duty.data[0] = a;
    duty.data[1] = b;
    duty.data[2] = c;
    duty.val     = 1'b1;
    @(negedge clk);
    duty.val     = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, t1, b0, b1, b2;
    enable    = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    duty      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm_h", {29'd0, pwm_h}, 32'd0);
    check("rst_pwm_l", {29'd0, pwm_l}, 32'd0);
    check("rst_sync",  {31'd0, sync}, 32'd0);
    check("rst_fault", {31'd0, fault_latched}, 32'd0);
    rst_n = 1'b1;

    // Start-up with all duties zero: low sides come on DEADTIME+1 edges after enable
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (D) @(negedge clk);
    check("start_l_early", {29'd0, pwm_l}, 32'd0);
    @(negedge clk);
    check("start_l_on", {29'd0, pwm_l}, 32'd7);
    check("start_h_off", {29'd0, pwm_h}, 32'd0);

    wait_sync("sync1_seen");
    check("sync1_time", cyc, 2 * P);
    t1 = cyc;
    wait_sync("sync2_seen");
    check("sync_period", cyc - t1, 2 * P);

    // Mid duty on A, short pulse on B, over-range clamp on C
    write_duty(18'd1250, 18'd20, 18'd3000);
    wait_sync("load1");
    wait_sync("steady1");
    b1 = h1_hi;
    b2 = h2_lo;
    measure_run(0, 0, 1'b1, len);
    check("mid_h0_on", len, 2 * 1250 - D);
    measure_run(0, 1, 1'b1, len);
    check("mid_l0_on", len, 2 * (P - 1250) - D);
    measure_run(0, 2, 1'b0, len);
    check("mid_dead_gap", len, D);
    measure_run(1, 1, 1'b0, len);
    check("short_l1_off", len, 90);
    check("short_h1_never", h1_hi - b1, 0);
    check("clamp_h2_const", h2_lo - b2, 0);

    // Mid-period write must not act before the next valley
    wait_sync("sh_s0");
    repeat (P) @(negedge clk);
    write_duty(18'd2000, 18'd20, 18'd3000);
    repeat (800) @(negedge clk);
    check("sh_before_h0", {31'd0, pwm_h[0]}, 32'd0);
    check("sh_before_l0", {31'd0, pwm_l[0]}, 32'd1);
    wait_sync("sh_s1");
    repeat (P + 800) @(negedge clk);
    check("sh_after_h0", {31'd0, pwm_h[0]}, 32'd1);
    check("sh_after_l0", {31'd0, pwm_l[0]}, 32'd0);

    // Write on the 1 -> 0 edge applies one full period later
    wait_sync("se_s0");
    repeat (2 * P - 1) @(negedge clk);
    write_duty(18'd500, 18'd20, 18'd3000);
    check("se_sync", {31'd0, sync}, 32'd1);
    repeat (P + 800) @(negedge clk);
    check("se_old_h0", {31'd0, pwm_h[0]}, 32'd1);
    wait_sync("se_s1");
    repeat (P + 800) @(negedge clk);
    check("se_new_h0", {31'd0, pwm_h[0]}, 32'd0);
    check("se_new_l0", {31'd0, pwm_l[0]}, 32'd1);

    // Fault latch
    check("flt_pre_h2", {31'd0, pwm_h[2]}, 32'd1);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    check("flt_latched", {31'd0, fault_latched}, 32'd1);
    check("flt_h_off", {29'd0, pwm_h}, 32'd0);
    check("flt_l_off", {29'd0, pwm_l}, 32'd0);
    fault     = 1'b1;
    fault_clr = 1'b1;
    @(negedge clk);
    fault     = 1'b0;
    check("flt_clr_ignored", {31'd0, fault_latched}, 32'd1);
    @(negedge clk);
    fault_clr = 1'b0;
    check("flt_cleared", {31'd0, fault_latched}, 32'd0);
    repeat (D) @(negedge clk);
    check("flt_resume_early", {26'd0, pwm_h, pwm_l}, 32'd0);
    @(negedge clk);
    check("flt_resume_h2", {31'd0, pwm_h[2]}, 32'd1);

    // Negative duty clamps to zero: phase A low side held on
    write_duty(18'h3FFFB, 18'd20, 18'd3000);
    wait_sync("neg_load");
    repeat (100) @(negedge clk);
    b0 = h0_hi;
    t1 = l0_lo;
    repeat (2 * P) @(negedge clk);
    check("neg_h0_never", h0_hi - b0, 0);
    check("neg_l0_const", l0_lo - t1, 0);

    // Reset mid-operation: asynchronous drop, then power-up behaviour
    check("rst2_pre_h2", {31'd0, pwm_h[2]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_h_async", {29'd0, pwm_h}, 32'd0);
    check("rst2_l_async", {29'd0, pwm_l}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (D) @(negedge clk);
    check("rst2_l_early", {29'd0, pwm_l}, 32'd0);
    @(negedge clk);
    check("rst2_l_on", {29'd0, pwm_l}, 32'd7);

    check("no_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_dtgen.md
# pwm_dtgen

Centre-aligned three-phase PWM generator with dead-time insertion. It sits directly downstream of `svmod` and consumes its per-phase duty output (`ph_data_t`). For each inverter leg it drives complementary high-side and low-side gate signals. Duty updates are double-buffered and applied at the carrier valley, and a latched fault input forces all gates off.

## Interface
- `PERIOD`, 2500: half carrier period in clocks; full carrier period is 2·PERIOD clocks (10 kHz at 50 MHz).
- `DEADTIME`, 50: clocks with both gates of a leg low around every transition (1 ≤ DEADTIME < PERIOD).
- `CW`, 18: width of each `duty.data[k]` element and of the internal compare registers.
- `clock`  in  `clock_t`: `clock.clk` is the single clock. `clock.rstn` is reset, asynchronous, active-low. `clock.ce` is unused.
- `duty`  in  `ph_data_t`: `data[0..2]` are duty compare values for phases A/B/C (signed CW bits). `val` is a 1-clk strobe.
- `enable`  in  1: gate enable; when 0, all gates are low.
- `fault`  in  1: synchronous fault request, already synchronised upstream.
- `fault_clr`  in  1: clears the latched fault.
- `pwm_h`  out  3: high-side gates, bit k = phase k.
- `pwm_l`  out  3: low-side gates.
- `sync`  out  1: one-clock pulse while the carrier is at the valley (`cnt==0`).
- `fault_latched`  out  1: latched fault status.

## Operation
- **Carrier:** `cnt` counts up 0..PERIOD-1, then down PERIOD..1, then repeats. Direction flag `up` is set while counting 0..PERIOD-1.
- **Duty capture:** on `duty.val`, each `data[k]` is clamped and written to `pend[k]`, and `pend_flag` is set.
  - Clamp rules: negative (MSB set) → 0; greater than PERIOD → PERIOD; otherwise the value unchanged.
- **Shadow load:** at the edge where `cnt` goes 1 → 0, `cmp[k] ← pend[k]` if `pend_flag` is set, and `pend_flag` is cleared.
  - If `duty.val` occurs on that same edge, `pend` takes the new value and `cmp` takes the old `pend`, so the new value applies one period later.
- **Reference:** registered. `ref[k] = up ? (cnt < cmp[k]) : (cnt <= cmp[k])`. This gives exactly 2·`cmp[k]` high clocks per period, centred on the valley.
  - `cmp=0` gives ref always low; `cmp=PERIOD` gives ref always high.
- **Per-phase FSM**, states SAFE, LOW, DEAD, HIGH:
  - LOW drives `pwm_l=1`. HIGH drives `pwm_h=1`. SAFE and DEAD drive both low.
  - LOW with `ref=1` → DEAD. HIGH with `ref=0` → DEAD. On entry to DEAD, `dcnt` is cleared.
  - In DEAD, `dcnt` increments each clock. Any change of `ref` while in DEAD clears `dcnt`.
  - When `dcnt==DEADTIME-1`, DEAD → HIGH if `ref=1`, else → LOW.
  - Effect: a ref pulse shorter than DEADTIME never turns the opposite gate on.
- **Gating:**
  - If `enable=0` or `fault_latched=1`, every FSM goes to SAFE on the next edge.
  - SAFE → DEAD (with `dcnt` cleared) once `enable=1` and `fault_latched=0`.
  - The carrier and the shadow logic keep running in all cases.
- **Fault latch:**
  - `fault=1` sets `fault_latched` at the next edge, and all FSMs are forced to SAFE on the same edge.
  - `fault_clr` clears the latch only when `fault=0` in that cycle. If `fault` and `fault_clr` are both high, the latch stays set.
- **Invariant:** `pwm_h[k] & pwm_l[k]` is never 1.

## Timing
- **Reset values:** `pwm_h=0`, `pwm_l=0`, `sync=0`, `fault_latched=0`, `cnt=0`, `up=1`, `cmp=pend=0`, `pend_flag=0`, `ref=0`, all FSMs in SAFE.
- **Reset mid-operation:** all outputs drop asynchronously. After release, the block behaves exactly as from power-up.
- **Ref to gates:** `ref` is one register stage after `cnt`. Gate outputs are FSM-state decodes, one more stage after that.
- **Transition latency:** if `ref` changes at edge t, the active gate drops at edge t+1 and the opposite gate rises at edge t+1+DEADTIME.
- **On-times:** `pwm_h` high time = 2·cmp − DEADTIME clocks; `pwm_l` high time = 2·(PERIOD−cmp) − DEADTIME clocks. Both hold whenever the respective term is > 0.
- **`sync`:** registered, high during exactly the clock in which `cnt==0`, once every 2·PERIOD clocks.
- **First `sync`:** occurs 2·PERIOD clocks after reset release. The `cnt=0` cycle at reset does not pulse.

## Test plan
- **Start-up:** reset, then `enable=1` with all duties 0. Required: `pwm_l=3'b111` exactly DEADTIME+1 clocks after `enable`; `pwm_h=0` throughout; `sync` period 5000 clocks.
- **Mid duty:** `duty=1250` on phase A (PERIOD=2500, DEADTIME=50). Required: `pwm_h[0]` high 2450 clocks and `pwm_l[0]` high 2450 clocks per 5000; each edge separated by 50 dead clocks; never both high.
- **Short pulse:** `duty=20` on phase B. Required: `pwm_h[1]` never rises; `pwm_l[1]` low for 90 clocks per period.
- **Shadow update:** write duty 2000 mid-period. Required: outputs unchanged until the edge ending at `cnt==0`.
  - Also: a write on the 1 → 0 edge takes effect one full period later.
- **Fault:** 1-clock `fault` pulse while `pwm_h=1`. Required: all gates 0 at the next edge and `fault_latched=1`.
  - `fault_clr` held together with `fault` is ignored.
  - `fault_clr` alone clears the latch; gates resume DEADTIME+1 clocks later.
- **Clamp:** `duty=3000` → `pwm_h` constant 1 after start-up; `duty=-5` → `pwm_l` constant 1.
